sram_ctrl: RTL and testbench
============================

// Module: sram_ctrl
// PURPOSE
//   Bridges the MEM stage's 32-bit word load/store requests to the 16-bit external SRAM.
//   Sits directly downstream of the MEM stage. Splits each word access into two half-word
//   SRAM cycles with programmable wait states. Drives ready low for the whole access;
//   the core uses ready to freeze every pipeline register until the access completes.
// PARAMETERS
//   BASE_ADDR    1024  byte address mapped to SRAM word 0
//   WAIT_CYCLES  2     extra cycles per half-word access (phase length = WAIT_CYCLES+1, >=1)
// PORTS
//   clk        in     1   core clock, rising edge
//   rst        in     1   asynchronous, active-low reset
//   wr_en      in     1   store request
//   rd_en      in     1   load request
//   address    in     32  byte address from the ALU result
//   wr_data    in     32  store data (val_rm)
//   rd_data    out    32  load data
//   ready      out    1   1 = no access in flight / access completes this cycle
//   SRAM_DQ    inout  16  SRAM data bus
//   SRAM_adr   out    18  SRAM half-word address
//   SRAM_UB_N  out    1   upper byte enable, tied 0
//   SRAM_LB_N  out    1   lower byte enable, tied 0
//   SRAM_WE_N  out    1   write enable, active low
//   SRAM_CE_N  out    1   chip enable, tied 0
//   SRAM_OE_N  out    1   output enable, tied 0
// BEHAVIOUR
//   - States: IDLE -> LO -> HI -> DONE -> IDLE. Wait counter cnt is 0..WAIT_CYCLES.
//   - Reset (rst=0, any time, including mid-access):
//     state=IDLE, cnt=0, rd_data=0, latched req/addr/data=0, SRAM_WE_N=1, SRAM_DQ=Z, SRAM_adr=0.
//   - IDLE: ready = ~(rd_en|wr_en), combinational, so the freeze is seen in the request cycle.
//     On rd_en|wr_en, latch op, address and wr_data, then go to LO.
//     If both rd_en and wr_en are high, the access is a write.
//   - Input changes after the latch are ignored until the controller returns to IDLE.
//   - Address: off = address - BASE_ADDR (32-bit, wrap).
//     SRAM_adr = {off[18:2], half}; half = 0 in LO, 1 in HI.
//     Bits above off[18] are discarded; no range check.
//   - LO and HI phases each last WAIT_CYCLES+1 cycles; cnt resets to 0 on each phase entry.
//   - Write phases: SRAM_DQ drives wr_data[15:0] in LO and wr_data[31:16] in HI.
//     SRAM_WE_N=0 while cnt<WAIT_CYCLES and 1 on the last cycle of each phase (data hold).
//   - Read phases: SRAM_DQ=Z, SRAM_WE_N=1. On the last LO cycle, rd_data[15:0] <= SRAM_DQ.
//     On the last HI cycle, rd_data[31:16] <= SRAM_DQ.
//   - rd_data changes only during reads and holds its value through writes and idle.
//   - DONE: ready=1 for exactly one cycle, SRAM_DQ=Z, SRAM_WE_N=1; pipeline advances.
//     Next state is always IDLE, so a new request is sampled the following cycle.
//   - Stall length: request cycle + 2*(WAIT_CYCLES+1) cycles with ready=0, then DONE.
//     With defaults this is 7 cycles low, then 1 cycle high.
//   - No request: stays in IDLE, ready=1, no SRAM activity (WE_N=1, DQ=Z).
// TESTING
//   - Reset: hold rst=0, then release -> ready=1, SRAM_WE_N=1, SRAM_DQ=Z, rd_data=0.
//   - Write: wr_en=1, address=1028, wr_data=32'hDEAD_BEEF.
//     -> SRAM_adr=2 with DQ=16'hBEEF, WE_N low 2 cycles; then SRAM_adr=3 with DQ=16'hDEAD.
//     -> ready low 7 cycles, then high 1.
//   - Read: SRAM model returns 16'hBEEF at adr 2 and 16'hDEAD at adr 3; rd_en=1, address=1028.
//     -> rd_data=32'hDEAD_BEEF in the DONE cycle.
//   - Both rd_en=1 and wr_en=1 with address=1024 -> write to SRAM_adr 0/1; rd_data unchanged.
//   - Mid-access reset: pull rst low during HI -> IDLE immediately, DQ=Z, WE_N=1.
//     A following read completes normally.
//   - Back-to-back: hold rd_en high across two accesses -> two distinct 7-low/1-high windows.
//     rd_data updates once per access.

Source files
------------

// File: rtl/sram_ctrl.sv
// -----------------------------------------------------------------------------
// sram_ctrl
//   Bridges 32-bit word load/store requests from the MEM stage to a 16-bit
//   external SRAM. Each word access is split into two half-word SRAM cycles
//   (low half, then high half). Each half lasts WAIT_CYCLES+1 clock cycles.
//   ready_o is held low for the whole access so that the core freezes its
//   pipeline registers until the access completes.
//
// Parameters
//   BASE_ADDR    byte address that maps to SRAM word 0
//   WAIT_CYCLES  extra cycles per half-word access (phase length WAIT_CYCLES+1)
//
// Ports
//   clk_i         core clock, rising edge
//   rst_ni        asynchronous active-low reset
//   wr_en_i       store request
//   rd_en_i       load request (a store wins if both are high)
//   address_i     byte address from the ALU result
//   wr_data_i     store data
//   rd_data_o     load data, updated only by reads
//   ready_o       1 = no access in flight, or the access completes this cycle
//   sram_dq_io    SRAM data bus (driven only during write phases)
//   sram_adr_o    SRAM half-word address
//   sram_ub_n_o   upper byte enable, tied active
//   sram_lb_n_o   lower byte enable, tied active
//   sram_we_n_o   write enable, active low
//   sram_ce_n_o   chip enable, tied active
//   sram_oe_n_o   output enable, tied active
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no access; ready follows the request combinationally, latch on req
// LO    | low half-word phase, SRAM address {off[18:2],0}
// HI    | high half-word phase, SRAM address {off[18:2],1}
// DONE  | access complete, ready high for one cycle, always back to IDLE
// -----------------------------------------------------------------------------
module sram_ctrl #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wr_en_i,
    input  logic        rd_en_i,
    input  logic [31:0] address_i,
    input  logic [31:0] wr_data_i,
    output logic [31:0] rd_data_o,
    output logic        ready_o,
    inout  wire  [15:0] sram_dq_io,
    output logic [17:0] sram_adr_o,
    output logic        sram_ub_n_o,
    output logic        sram_lb_n_o,
    output logic        sram_we_n_o,
    output logic        sram_ce_n_o,
    output logic        sram_oe_n_o
);

    localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          op_wr_q, op_wr_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rd_data_q, rd_data_d;

    logic [31:0]   off;
    logic          phase_last;
    logic          dq_oe;
    logic [15:0]   dq_out;
    logic          adr_act;
    logic          half;

    // Byte offset into the SRAM window; wraps, no range check.
    assign off        = addr_q - 32'(BASE_ADDR);
    assign phase_last = (cnt_q == CNT_LAST);

    // Only the word index of the offset reaches the SRAM address pins.
    logic unused_off_bits;
    assign unused_off_bits = ^{off[31:19], off[1:0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_wr_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_wr_q   <= op_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_wr_d     = op_wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_data_d   = rd_data_q;
        ready_o     = 1'b0;
        sram_we_n_o = 1'b1;
        dq_oe       = 1'b0;
        dq_out      = '0;
        adr_act     = 1'b0;
        half        = 1'b0;

        case (state_q)
            IDLE: begin
                // Combinational so the core freezes in the request cycle itself.
                ready_o = ~(rd_en_i | wr_en_i);
                if (rd_en_i | wr_en_i) begin
                    op_wr_d = wr_en_i;
                    addr_d  = address_i;
                    wdata_d = wr_data_i;
                    cnt_d   = '0;
                    state_d = LO;
                end
            end

            LO: begin
                adr_act = 1'b1;
                half    = 1'b0;
                if (op_wr_q) begin
                    dq_oe       = 1'b1;
                    dq_out      = wdata_q[15:0];
                    // Last cycle of the phase releases WE_N with data still held.
                    sram_we_n_o = (cnt_q < CNT_LAST) ? 1'b0 : 1'b1;
                end
                if (phase_last) begin
                    if (!op_wr_q) begin
                        rd_data_d[15:0] = sram_dq_io;
                    end
                    cnt_d   = '0;
                    state_d = HI;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            HI: begin
                adr_act = 1'b1;
                half    = 1'b1;
                if (op_wr_q) begin
                    dq_oe       = 1'b1;
                    dq_out      = wdata_q[31:16];
                    sram_we_n_o = (cnt_q < CNT_LAST) ? 1'b0 : 1'b1;
                end
                if (phase_last) begin
                    if (!op_wr_q) begin
                        rd_data_d[31:16] = sram_dq_io;
                    end
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                ready_o = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sram_dq_io  = dq_oe ? dq_out : 16'hzzzz;
    assign sram_adr_o  = adr_act ? {off[18:2], half} : 18'd0;
    assign rd_data_o   = rd_data_q;
    assign sram_ub_n_o = 1'b0;
    assign sram_lb_n_o = 1'b0;
    assign sram_ce_n_o = 1'b0;
    assign sram_oe_n_o = 1'b0;

endmodule

// File: tb/tb_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_ctrl
//   Bench for sram_ctrl with a small behavioural SRAM on the data bus.
//   Expected load data is pushed to a queue when an access is issued and
//   popped when the controller signals completion.
// -----------------------------------------------------------------------------
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        ready;
    wire  [15:0] dq;
    logic [17:0] adr;
    logic        ub_n, lb_n, we_n, ce_n, oe_n;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sram_ctrl #(.BASE_ADDR(1024), .WAIT_CYCLES(2)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .wr_en_i     (wr_en),
        .rd_en_i     (rd_en),
        .address_i   (address),
        .wr_data_i   (wr_data),
        .rd_data_o   (rd_data),
        .ready_o     (ready),
        .sram_dq_io  (dq),
        .sram_adr_o  (adr),
        .sram_ub_n_o (ub_n),
        .sram_lb_n_o (lb_n),
        .sram_we_n_o (we_n),
        .sram_ce_n_o (ce_n),
        .sram_oe_n_o (oe_n)
    );

    // Behavioural SRAM: stores on WE_N low, drives the bus during loads.
    logic [15:0] sram_mem [0:31];
    logic        model_oe = 1'b0;
    assign dq = (model_oe && we_n) ? sram_mem[adr[4:0]] : 16'hzzzz;
    always @(posedge clk) begin
        if (!we_n) sram_mem[adr[4:0]] <= dq;
    end

    // Reference contents of the SRAM as the bench intends them to be.
    logic [15:0] ref_mem [0:31];
    logic [31:0] exp_rd = '0;
    logic [31:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic access(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input bit hold);
        logic [31:0] off;
        logic [17:0] base;
        logic [31:0] exp_val;
        int          lo_cnt;
        int          we_cnt;
        bit          done;
        off  = a - 32'd1024;
        base = {off[18:2], 1'b0};
        if (w) begin
            ref_mem[base[4:0]]        = d[15:0];
            ref_mem[base[4:0] + 5'd1] = d[31:16];
        end else if (r) begin
            exp_rd = {ref_mem[base[4:0] + 5'd1], ref_mem[base[4:0]]};
        end
        exp_q.push_back(exp_rd);

        @(posedge clk); #1;
        wr_en    = w;
        rd_en    = r;
        address  = a;
        wr_data  = d;
        model_oe = r & ~w;
        lo_cnt   = 0;
        we_cnt   = 0;
        done     = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (ready) begin
                done = 1;
                break;
            end
            lo_cnt++;
            if (!we_n) begin
                we_cnt++;
                if (we_cnt <= 2) begin
                    chk("wr_adr_lo", {14'd0, adr}, {14'd0, base});
                    chk("wr_dq_lo", {16'd0, dq}, {16'd0, d[15:0]});
                end else begin
                    chk("wr_adr_hi", {14'd0, adr}, {14'd0, base | 18'd1});
                    chk("wr_dq_hi", {16'd0, dq}, {16'd0, d[31:16]});
                end
            end
            @(posedge clk); #1;
            if (!hold && cyc == 0) begin
                // Inputs after the latch must be ignored.
                wr_en   = 1'b0;
                rd_en   = 1'b0;
                address = $urandom;
                wr_data = $urandom;
            end
        end
        if (!done) begin
            chk("timeout", 32'd0, 32'd1);
        end else begin
            exp_val = exp_q.pop_front();
            chk("stall_len", lo_cnt, 7);
            chk("we_pulses", we_cnt, w ? 4 : 0);
            chk("done_we_n", {31'd0, we_n}, 32'd1);
            chk("rd_data", rd_data, exp_val);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_we_n", {31'd0, we_n}, 32'd1);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_adr", {14'd0, adr}, 32'd0);
        chk("tie_ce_oe_ub_lb", {28'd0, ce_n, oe_n, ub_n, lb_n}, 32'd0);
        rst_n = 1'b1;

        // Idle with no request
        repeat (2) @(negedge clk);
        chk("idle_ready", {31'd0, ready}, 32'd1);
        chk("idle_we_n", {31'd0, we_n}, 32'd1);

        // Write then read back the same word
        access(1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        chk("post_done_ready", {31'd0, ready}, 32'd1);
        access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);

        // Both enables: treated as a write, rd_data unchanged
        access(1'b1, 1'b1, 32'd1024, 32'h1234_5678, 1'b0);
        access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);

        // A couple of random writes with read-back
        for (int i = 0; i < 2; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            a = 32'd1040 + 32'(i * 4);
            d = $urandom;
            access(1'b1, 1'b0, a, d, 1'b0);
            access(1'b0, 1'b1, a, 32'h0, 1'b0);
        end

        // Mid-access reset during the HI phase of a write
        @(posedge clk); #1;
        wr_en   = 1'b1;
        address = 32'd1032;
        wr_data = 32'hCAFE_F00D;
        model_oe = 1'b0;
        @(posedge clk); #1;
        wr_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid_hi_adr", {14'd0, adr}, 32'd5);
        chk("mid_hi_we_n", {31'd0, we_n}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we_n", {31'd0, we_n}, 32'd1);
        chk("mid_rst_ready", {31'd0, ready}, 32'd1);
        chk("mid_rst_adr", {14'd0, adr}, 32'd0);
        chk("mid_rst_rd_data", rd_data, 32'd0);
        exp_rd = '0;
        @(negedge clk);
        rst_n = 1'b1;
        access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);

        // Back-to-back reads with rd_en held high across both
        access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b1);
        access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
        @(negedge clk);
        chk("b2b_idle_ready", {31'd0, ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
